// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers
// Shift-add multiply and restoring divide on magnitudes; signs are applied in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             Flush,
  input  logic             WriteHi,
  input  logic             WriteLo,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      counter;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div0;
  logic [WIDTH-1:0]   m_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi, lo;
  logic               done_q;

  logic               op_signed;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               last_iter;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (Flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (Start) state_nxt = RUN;
        RUN:     if (last_iter) state_nxt = FIX;
        FIX:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    Busy  = (state != IDLE);
    Done  = done_q;
    HiOut = hi;
    LoOut = lo;
  end

  always_comb begin
    op_signed = ~Op[0];
    a_abs     = (op_signed && OperandA[WIDTH-1]) ? (~OperandA + 1'b1) : OperandA;
    b_abs     = (op_signed && OperandB[WIDTH-1]) ? (~OperandB + 1'b1) : OperandB;
    last_iter = (counter == CW'(WIDTH - 1));
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m_q} : '0);
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, m_q};
    prod_fix  = neg_q ? (~acc + 1'b1) : acc;
    // Divide by zero leaves quotient all ones and remainder |A|; sign-fixing |A| restores A.
    quo_fix   = div0 ? '1 : (neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0]);
    rem_fix   = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      div0    <= 1'b0;
      m_q     <= '0;
      acc     <= '0;
      hi      <= '0;
      lo      <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (WriteHi) hi <= WriteData;
      if (WriteLo) lo <= WriteData;
      if (Flush) begin
        counter <= '0;
      end else begin
        case (state)
          IDLE: if (Start) begin
            counter <= '0;
            is_div  <= Op[1];
            neg_q   <= op_signed & (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
            neg_r   <= op_signed & OperandA[WIDTH-1];
            div0    <= Op[1] & (OperandB == '0);
            m_q     <= Op[1] ? b_abs : a_abs;
            acc     <= {{WIDTH{1'b0}}, (Op[1] ? a_abs : b_abs)};
          end
          RUN: begin
            counter <= counter + 1'b1;
            if (!is_div)
              acc <= {mul_sum, acc[WIDTH-1:1]};
            else if (!div_diff[WIDTH])
              acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
              acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          end
          FIX: begin
            // Commit overrides a same-edge MTHI/MTLO write.
            done_q <= 1'b1;
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         Start;
  logic [1:0]   Op;
  logic [W-1:0] OperandA, OperandB;
  logic         Flush, WriteHi, WriteLo;
  logic [W-1:0] WriteData;
  logic         Busy, Done;
  logic [W-1:0] HiOut, LoOut;

  int checks = 0;
  int fails  = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB), .Flush(Flush),
    .WriteHi(WriteHi), .WriteLo(WriteLo), .WriteData(WriteData),
    .Busy(Busy), .Done(Done), .HiOut(HiOut), .LoOut(LoOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation from IDLE; optional Start pulse while busy and MTLO on the FIX edge.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                       input logic [W-1:0] exp_lo, input bit mid_start, input bit wr_fix);
    int n;
    int extra_done;
    Op = op; OperandA = a; OperandB = b; Start = 1'b1;
    tick();
    Start = 1'b0;
    OperandA = $urandom; OperandB = $urandom;
    n = 0;
    while (Busy && n < 100) begin
      Start     = mid_start && (n == 5);
      WriteLo   = wr_fix && (n == W);
      WriteData = 32'h0000AAAA;
      tick();
      n++;
    end
    Start = 1'b0; WriteLo = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(n), 64'(W + 1));
    chk({tag, "_done"}, 64'(Done), 64'd1);
    chk({tag, "_hi"}, 64'(HiOut), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(LoOut), 64'(exp_lo));
    extra_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Done || Busy) extra_done++;
    end
    chk({tag, "_quiet_after"}, 64'(extra_done), 64'd0);
  endtask

  task automatic abort_test(input string tag, input bit use_reset,
                            input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int dn;
    WriteHi = 1'b1; WriteData = 32'h11; tick();
    WriteHi = 1'b0; WriteLo = 1'b1; WriteData = 32'h22; tick();
    WriteLo = 1'b0;
    chk({tag, "_mthi"}, 64'(HiOut), 64'h11);
    chk({tag, "_mtlo"}, 64'(LoOut), 64'h22);
    Op = 2'b00; OperandA = 32'd5; OperandB = 32'd5; Start = 1'b1;
    tick();
    Start = 1'b0;
    dn = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (Done) dn++;
    end
    chk({tag, "_busy_mid"}, 64'(Busy), 64'd1);
    if (use_reset) reset = 1'b1; else Flush = 1'b1;
    tick();
    reset = 1'b0; Flush = 1'b0;
    chk({tag, "_busy_drop"}, 64'(Busy), 64'd0);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Done) dn++;
    end
    chk({tag, "_no_done"}, 64'(dn), 64'd0);
    chk({tag, "_hi"}, 64'(HiOut), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(LoOut), 64'(exp_lo));
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; Op = 2'b00; OperandA = '0; OperandB = '0;
    Flush = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0; WriteData = '0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_hi", 64'(HiOut), 64'h0);
    chk("reset_lo", 64'(LoOut), 64'h0);
    chk("reset_busy", 64'(Busy), 64'h0);
    chk("reset_done", 64'(Done), 64'h0);

    Start = 1'b1; Flush = 1'b1; Op = 2'b01; OperandA = 32'd9; OperandB = 32'd9;
    tick();
    Start = 1'b0; Flush = 1'b0;
    chk("flush_beats_start", 64'(Busy), 64'h0);

    do_op("mult_neg",   2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
    do_op("multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0);
    do_op("div_neg",    2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    do_op("div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
    do_op("divu_zero",  2'b11, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b0, 1'b0);
    do_op("divu_100_7", 2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b0);
    do_op("div_zero_n", 2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0, 1'b0);
    do_op("div_pos_neg",2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 1'b0);

    abort_test("flush", 1'b0, 32'h11, 32'h22);
    abort_test("rst",   1'b1, 32'h0,  32'h0);

    do_op("multu_wr_fix", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
